// File: rtl/apb_register_slave_pkg.sv
// Shared types and constants for the APB register completer.
package apb_register_slave_pkg;

  localparam int unsigned APB_WORD_SHIFT = 2;
  localparam int unsigned APB_WAIT_W     = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} apb_slave_state_t;
  typedef enum logic {APB_OKAY, APB_ERROR} apb_error_t;
  typedef enum logic {APB_READ, APB_WRITE} apb_direction_t;
  typedef enum logic {APB_SETUP_PHASE, APB_ACCESS_PHASE} apb_enable_t;
  typedef enum logic {APB_WAIT, APB_READY} apb_ready_t;
  typedef enum logic {APB_NOT_SELECTED, APB_SELECTED} apb_select_t;

  // Transfer attributes captured in the setup phase.
  typedef struct packed {
    apb_direction_t dir;
    logic           priv;
  } apb_ctrl_t;

endpackage

// File: rtl/apb_wait_counter.sv
// Wait-state counter: cleared by load, advanced by en, flags when WAIT_STATES is reached.
module apb_wait_counter
  import apb_register_slave_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  logic [APB_WAIT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + APB_WAIT_W'(1);
    end
  end

  assign expired = (count_q == APB_WAIT_W'(WAIT_STATES));

endmodule

// File: rtl/apb_register_slave.sv
// APB completer with DEPTH registers, programmable wait states, byte strobes and error response.
module apb_register_slave
  import apb_register_slave_pkg::*;
#(
  parameter int unsigned N           = 32,
  parameter int unsigned A           = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [N-1:0] ID_VALUE   = N'(32'hA9B0_0001)
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [A-1:0]         PADDR,
  input  logic [2:0]           PPROT,
  input  logic [N-1:0]         PWDATA,
  input  logic [N/8-1:0]       PSTRB,
  output logic                 PREADY,
  output logic [N-1:0]         PRDATA,
  output logic                 PSLVERR,
  output logic [DEPTH*N-1:0]   reg_q
);

  localparam int unsigned STRB_W = N / 8;
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned WORD_W = A - APB_WORD_SHIFT;

  apb_slave_state_t  state_q, state_d;
  logic [A-1:0]      addr_q;
  logic [N-1:0]      wdata_q;
  logic [STRB_W-1:0] strb_q;
  apb_ctrl_t         ctrl_q;
  logic              latch, cnt_load, cnt_en, cnt_expired;
  apb_error_t        err;
  logic              do_write;
  logic [WORD_W-1:0] word;
  logic [IDX_W-1:0]  idx;
  logic [N-1:0]      regs [DEPTH];
  logic              pready_q, pslverr_q;
  logic [N-1:0]      prdata_q;
  logic              unused_prot;

  assign unused_prot = ^PPROT[2:1];

  apb_wait_counter #(.WAIT_STATES(WAIT_STATES)) u_wait (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .load    (cnt_load),
    .en      (cnt_en),
    .expired (cnt_expired)
  );

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; a setup phase in DONE chains straight into the next transfer.
  always_comb begin
    state_d  = state_q;
    latch    = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d  = ACCESS;
          latch    = 1'b1;
          cnt_load = 1'b1;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (cnt_expired) begin
          state_d = DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        if (PSEL && !PENABLE) begin
          state_d  = ACCESS;
          latch    = 1'b1;
          cnt_load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      ctrl_q  <= '{dir: APB_READ, priv: 1'b0};
    end else if (latch) begin
      addr_q  <= PADDR;
      wdata_q <= PWDATA;
      strb_q  <= PSTRB;
      ctrl_q  <= '{dir: apb_direction_t'(PWRITE), priv: PPROT[0]};
    end
  end

  // Range check uses every address bit so high addresses never alias onto low registers.
  assign word = addr_q[A-1:APB_WORD_SHIFT];
  assign idx  = addr_q[IDX_W+APB_WORD_SHIFT-1:APB_WORD_SHIFT];

  always_comb begin
    err = APB_OKAY;
    if ((addr_q[APB_WORD_SHIFT-1:0] != '0) ||
        (word >= WORD_W'(DEPTH)) ||
        ((ctrl_q.dir == APB_WRITE) && ((word == '0) || !ctrl_q.priv))) begin
      err = APB_ERROR;
    end
  end

  assign do_write = (state_q == DONE) && (ctrl_q.dir == APB_WRITE) && (err == APB_OKAY);

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      pready_q  <= (state_d == DONE);
      pslverr_q <= (state_d == DONE) && (err == APB_ERROR);
      prdata_q  <= ((state_d == DONE) && (ctrl_q.dir == APB_READ) && (err == APB_OKAY))
                   ? regs[idx] : '0;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      regs[0] <= ID_VALUE;
      for (int i = 1; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (do_write) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (strb_q[k]) begin
          regs[idx][k*8 +: 8] <= wdata_q[k*8 +: 8];
        end
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign reg_q[g*N +: N] = regs[g];
  end

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_register_slave.sv
// Self-checking bench: two completers (0 and 3 wait states) on a shared bus, checked against an array model.
module tb_apb_register_slave;

  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, psel0, psel3, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [2:0]  pprot;
  logic [3:0]  pstrb;
  logic        pready0, pslverr0, pready3, pslverr3;
  logic [31:0] prdata0, prdata3;
  logic [511:0] regq0, regq3;

  int errors = 0;
  int checks = 0;
  logic [31:0] m0 [16];
  logic [31:0] m3 [16];

  apb_register_slave #(.WAIT_STATES(0)) dut0 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PPROT(pprot), .PWDATA(pwdata), .PSTRB(pstrb),
    .PREADY(pready0), .PRDATA(prdata0), .PSLVERR(pslverr0), .reg_q(regq0));

  apb_register_slave #(.WAIT_STATES(3)) dut3 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel3), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PPROT(pprot), .PWDATA(pwdata), .PSTRB(pstrb),
    .PREADY(pready3), .PRDATA(prdata3), .PSLVERR(pslverr3), .reg_q(regq3));

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m0[i] = '0;
      m3[i] = '0;
    end
    m0[0] = ID;
    m3[0] = ID;
  endtask

  // Behavioural effect of one complete transfer: error decision, read value, register update.
  task automatic model_xfer(input int which, input logic [31:0] addr, input logic wr,
                            input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                            output logic [31:0] erd, output logic eerr);
    logic [31:0] w;
    int unsigned wi;
    wi   = addr / 4;
    eerr = (addr % 4 != 0) || (wi >= 16) || (wr && (wi == 0 || !pr[0]));
    erd  = '0;
    if (!eerr) begin
      w = (which == 0) ? m0[wi] : m3[wi];
      if (!wr) begin
        erd = w;
      end else begin
        for (int k = 0; k < 4; k++) if (st[k]) w[k*8 +: 8] = wd[k*8 +: 8];
        if (which == 0) m0[wi] = w; else m3[wi] = w;
      end
    end
  endtask

  function automatic logic [511:0] packed_model(input int which);
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = (which == 0) ? m0[i] : m3[i];
    return v;
  endfunction

  // APB master: setup, access until PREADY, then hold through the completing edge.
  task automatic xfer(input int which, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                      output logic [31:0] rd, output logic er, output int lat);
    if (which == 0) psel0 = 1'b1; else psel3 = 1'b1;
    penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = st; pprot = pr;
    @(posedge clk); #1;
    penable = 1'b1;
    lat = 1;
    while (!((which == 0) ? pready0 : pready3) && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = (which == 0) ? prdata0 : prdata3;
    er = (which == 0) ? pslverr0 : pslverr3;
    @(posedge clk); #1;
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    checks++; if (pready0 !== 1'b0 || pready3 !== 1'b0) begin errors++; $display("FAIL reset_pready got %b/%b exp 0/0", pready0, pready3); end
    checks++; if (prdata0 !== 32'h0 || prdata3 !== 32'h0) begin errors++; $display("FAIL reset_prdata got %h/%h exp 0", prdata0, prdata3); end
    checks++; if (pslverr0 !== 1'b0 || pslverr3 !== 1'b0) begin errors++; $display("FAIL reset_pslverr got %b/%b exp 0", pslverr0, pslverr3); end
    checks++; if (regq0 !== packed_model(0)) begin errors++; $display("FAIL reset_regq0 got %h exp %h", regq0, packed_model(0)); end
    checks++; if (regq3 !== packed_model(3)) begin errors++; $display("FAIL reset_regq3 got %h exp %h", regq3, packed_model(3)); end
  endtask

  task automatic test_basic();
    logic [31:0] rd, erd; logic er, eer; int lat;
    xfer(0, 32'h4, 1'b1, 32'hDEADBEEF, 4'hF, 3'b001, rd, er, lat);
    model_xfer(0, 32'h4, 1'b1, 32'hDEADBEEF, 4'hF, 3'b001, erd, eer);
    checks++; if (lat !== 2 || er !== 1'b0) begin errors++; $display("FAIL basic_write lat=%0d err=%b exp lat=2 err=0", lat, er); end
    checks++; if (regq0[32 +: 32] !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_regq got %h exp deadbeef", regq0[32 +: 32]); end
    xfer(0, 32'h4, 1'b0, 32'h0, 4'h0, 3'b001, rd, er, lat);
    checks++; if (lat !== 2 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_read lat=%0d err=%b data=%h exp 2/0/deadbeef", lat, er, rd); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic er; int lat;
    xfer(3, 32'h0, 1'b0, 32'h0, 4'h0, 3'b000, rd, er, lat);
    checks++; if (lat !== 5 || er !== 1'b0 || rd !== ID) begin errors++; $display("FAIL wait_read lat=%0d err=%b data=%h exp 5/0/%h", lat, er, rd, ID); end
  endtask

  task automatic test_strobes();
    logic [31:0] rd, erd; logic er, eer; int lat;
    xfer(0, 32'h8, 1'b1, 32'hFFFFFFFF, 4'hF, 3'b001, rd, er, lat);
    model_xfer(0, 32'h8, 1'b1, 32'hFFFFFFFF, 4'hF, 3'b001, erd, eer);
    xfer(0, 32'h8, 1'b1, 32'h11223344, 4'b0101, 3'b001, rd, er, lat);
    model_xfer(0, 32'h8, 1'b1, 32'h11223344, 4'b0101, 3'b001, erd, eer);
    xfer(0, 32'h8, 1'b1, 32'h00000000, 4'b0000, 3'b001, rd, er, lat);
    model_xfer(0, 32'h8, 1'b1, 32'h00000000, 4'b0000, 3'b001, erd, eer);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL strb_zero_err got %b exp 0", er); end
    xfer(0, 32'h8, 1'b0, 32'h0, 4'h0, 3'b001, rd, er, lat);
    checks++; if (rd !== 32'hFF22FF44 || er !== 1'b0) begin errors++; $display("FAIL strb_read got %h err=%b exp ff22ff44/0", rd, er); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    xfer(0, 32'h40, 1'b1, 32'h12345678, 4'hF, 3'b001, rd, er, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_range got %b exp 1", er); end
    xfer(0, 32'h6, 1'b0, 32'h0, 4'h0, 3'b001, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_misaligned err=%b data=%h exp 1/0", er, rd); end
    xfer(0, 32'h0, 1'b1, 32'h12345678, 4'hF, 3'b001, rd, er, lat);
    checks++; if (er !== 1'b1 || regq0[31:0] !== ID) begin errors++; $display("FAIL err_readonly err=%b reg0=%h exp 1/%h", er, regq0[31:0], ID); end
    xfer(0, 32'hC, 1'b1, 32'h12345678, 4'hF, 3'b000, rd, er, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_unpriv got %b exp 1", er); end
    checks++; if (regq0 !== packed_model(0)) begin errors++; $display("FAIL err_nochange got %h exp %h", regq0, packed_model(0)); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, erd; logic er, eer; int lat1, lat2;
    xfer(0, 32'h14, 1'b1, 32'hA5A5_0001, 4'hF, 3'b001, rd, er, lat1);
    model_xfer(0, 32'h14, 1'b1, 32'hA5A5_0001, 4'hF, 3'b001, erd, eer);
    checks++; if (pready0 !== 1'b0) begin errors++; $display("FAIL b2b_pulse1 pready=%b exp 0", pready0); end
    xfer(0, 32'h18, 1'b1, 32'h5A5A_0002, 4'hF, 3'b011, rd, er, lat2);
    model_xfer(0, 32'h18, 1'b1, 32'h5A5A_0002, 4'hF, 3'b011, erd, eer);
    checks++; if (lat1 !== 2 || lat2 !== 2) begin errors++; $display("FAIL b2b_latency got %0d/%0d exp 2/2", lat1, lat2); end
    checks++; if (pready0 !== 1'b0) begin errors++; $display("FAIL b2b_pulse2 pready=%b exp 0", pready0); end
    checks++; if (regq0 !== packed_model(0)) begin errors++; $display("FAIL b2b_regs got %h exp %h", regq0, packed_model(0)); end
  endtask

  task automatic test_protocol_faults();
    logic seen;
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hCAFEF00D; pstrb = 4'hF; pprot = 3'b001;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel3 = 1'b0; penable = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (pready3) seen = 1'b1; end
    checks++; if (seen !== 1'b0 || regq3 !== packed_model(3)) begin errors++; $display("FAIL psel_drop pready_seen=%b reg4=%h exp 0/%h", seen, regq3[128 +: 32], m3[4]); end
    psel0 = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h10;
    seen = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (pready0) seen = 1'b1; end
    psel0 = 1'b0; penable = 1'b0;
    checks++; if (seen !== 1'b0 || regq0 !== packed_model(0)) begin errors++; $display("FAIL enable_without_setup pready_seen=%b exp 0", seen); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd, erd; logic er, eer; int lat;
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC; pwdata = 32'h12345678; pstrb = 4'hF; pprot = 3'b001;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; psel3 = 1'b0; penable = 1'b0;
    model_reset();
    checks++; if (pready3 !== 1'b0) begin errors++; $display("FAIL abort_pready got %b exp 0", pready3); end
    repeat (6) @(posedge clk);
    #1;
    checks++; if (regq3[96 +: 32] !== 32'h0 || pready3 !== 1'b0) begin errors++; $display("FAIL abort_reg3 got %h pready=%b exp 0/0", regq3[96 +: 32], pready3); end
    xfer(3, 32'hC, 1'b1, 32'h0BAD_CAFE, 4'hF, 3'b001, rd, er, lat);
    model_xfer(3, 32'hC, 1'b1, 32'h0BAD_CAFE, 4'hF, 3'b001, erd, eer);
    checks++; if (lat !== 5 || er !== 1'b0 || regq3 !== packed_model(3)) begin errors++; $display("FAIL abort_recover lat=%0d err=%b reg3=%h exp 5/0/0badcafe", lat, er, regq3[96 +: 32]); end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, addr, wd; logic er, eer, wr; logic [3:0] st; logic [2:0] pr; int lat, which;
    for (int n = 0; n < 60; n++) begin
      which = ($urandom_range(0, 3) == 0) ? 3 : 0;
      addr  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 80)) : 32'($urandom_range(0, 19) * 4);
      if ($urandom_range(0, 15) == 0) addr = $urandom;
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      st = 4'($urandom);
      pr = ($urandom_range(0, 4) == 0) ? 3'($urandom) & 3'b110 : 3'($urandom) | 3'b001;
      xfer(which, addr, wr, wd, st, pr, rd, er, lat);
      model_xfer(which, addr, wr, wd, st, pr, erd, eer);
      checks++;
      if (lat !== 2 + ((which == 0) ? 0 : 3) || er !== eer || (!wr && rd !== erd)) begin
        errors++;
        $display("FAIL rand_xfer n=%0d dut=%0d addr=%h wr=%b lat=%0d err=%b data=%h exp lat=%0d err=%b data=%h",
                 n, which, addr, wr, lat, er, rd, 2 + ((which == 0) ? 0 : 3), eer, erd);
      end
      checks++;
      if (((which == 0) ? regq0 : regq3) !== packed_model(which)) begin
        errors++;
        $display("FAIL rand_regs n=%0d dut=%0d addr=%h", n, which, addr);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    model_reset();
    test_reset();
    test_basic();
    test_wait_states();
    test_strobes();
    test_errors();
    test_back_to_back();
    test_protocol_faults();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
